// File: rtl/tlb_search_arbiter.sv
// Arbitrates the single TLB search port between inst fetch, data translation and the TLBP probe.
// Grants are combinational. The TLB result is registered and returned with a per-owner valid pulse.
module tlb_search_arbiter #(
   parameter int unsigned TLBNUM       = 16,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned WE_HOLD      = 1
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      inst_req,
   input  logic [18:0]               inst_vpn2,
   input  logic                      inst_odd,
   input  logic [7:0]                inst_asid,
   input  logic                      data_req,
   input  logic [18:0]               data_vpn2,
   input  logic                      data_odd,
   input  logic [7:0]                data_asid,
   input  logic                      probe_req,
   input  logic [18:0]               probe_vpn2,
   input  logic                      probe_odd,
   input  logic [7:0]                probe_asid,

   output logic                      inst_ack,
   output logic                      data_ack,
   output logic                      probe_ack,
   output logic                      inst_rsp_valid,
   output logic                      data_rsp_valid,
   output logic                      probe_rsp_valid,

   output logic                      rsp_found,
   output logic [$clog2(TLBNUM)-1:0] rsp_index,
   output logic [19:0]               rsp_pfn,
   output logic [2:0]                rsp_c,
   output logic                      rsp_d,
   output logic                      rsp_v,

   output logic [18:0]               s_vpn2,
   output logic                      s_odd_page,
   output logic [7:0]                s_asid,
   input  logic                      s_found,
   input  logic [$clog2(TLBNUM)-1:0] s_index,
   input  logic [19:0]               s_pfn,
   input  logic [2:0]                s_c,
   input  logic                      s_d,
   input  logic                      s_v,

   input  logic                      tlb_we,
   input  logic                      cancel
);

   localparam int unsigned IDX_W      = $clog2(TLBNUM);
   localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);
   localparam logic [1:0]  HOLD_INIT  = (WE_HOLD > 0) ? 2'(WE_HOLD - 1) : 2'd0;
   localparam logic [1:0]  OWN_INST   = 2'd0;
   localparam logic [1:0]  OWN_DATA   = 2'd1;
   localparam logic [1:0]  OWN_PROBE  = 2'd2;

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t           state, state_n;
   logic [1:0]       hold_cnt, hold_cnt_n;
   logic [2:0]       starve_cnt;
   logic             blocked;
   logic             force_inst;
   logic             gnt_inst, gnt_data, gnt_probe, gnt_any;
   logic             rsp_pend;
   logic [1:0]       rsp_owner;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         hold_cnt <= 2'd0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_cnt_n;
      end
   end

   // Next state: a TLB write keeps the search port closed for WE_HOLD extra cycles
   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      case (state)
         RUN: begin
            if (tlb_we && (WE_HOLD > 0)) begin
               state_n    = HOLD;
               hold_cnt_n = HOLD_INIT;
            end
         end
         HOLD: begin
            if (tlb_we) begin
               hold_cnt_n = HOLD_INIT;
            end else if (hold_cnt == 2'd0) begin
               state_n = RUN;
            end else begin
               hold_cnt_n = hold_cnt - 2'd1;
            end
         end
         default: state_n = RUN;
      endcase
   end

   // FSM output: grant window
   always_comb begin
      blocked = 1'b0;
      if (reset || tlb_we || cancel || (state == HOLD)) begin
         blocked = 1'b1;
      end
   end

   // Fixed priority probe > data > inst, overridden by the inst starvation guard
   always_comb begin
      gnt_inst   = 1'b0;
      gnt_data   = 1'b0;
      gnt_probe  = 1'b0;
      force_inst = inst_req && (starve_cnt == STARVE_MAX);
      if (!blocked) begin
         if (force_inst)     gnt_inst  = 1'b1;
         else if (probe_req) gnt_probe = 1'b1;
         else if (data_req)  gnt_data  = 1'b1;
         else if (inst_req)  gnt_inst  = 1'b1;
      end
      gnt_any = gnt_inst | gnt_data | gnt_probe;
   end

   assign inst_ack  = gnt_inst;
   assign data_ack  = gnt_data;
   assign probe_ack = gnt_probe;

   // Search port follows the winner; inst fields when idle
   always_comb begin
      s_vpn2     = inst_vpn2;
      s_odd_page = inst_odd;
      s_asid     = inst_asid;
      if (gnt_probe) begin
         s_vpn2     = probe_vpn2;
         s_odd_page = probe_odd;
         s_asid     = probe_asid;
      end else if (gnt_data) begin
         s_vpn2     = data_vpn2;
         s_odd_page = data_odd;
         s_asid     = data_asid;
      end
   end

   // Response register: data holds between grants, valid pulses for one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_pend  <= 1'b0;
         rsp_owner <= OWN_INST;
         rsp_found <= 1'b0;
         rsp_index <= '0;
         rsp_pfn   <= 20'd0;
         rsp_c     <= 3'd0;
         rsp_d     <= 1'b0;
         rsp_v     <= 1'b0;
      end else begin
         rsp_pend <= gnt_any;
         if (gnt_any) begin
            rsp_owner <= gnt_probe ? OWN_PROBE : (gnt_data ? OWN_DATA : OWN_INST);
            rsp_found <= s_found;
            rsp_index <= IDX_W'(s_index);
            rsp_pfn   <= s_pfn;
            rsp_c     <= s_c;
            rsp_d     <= s_d;
            rsp_v     <= s_v;
         end
      end
   end

   assign inst_rsp_valid  = rsp_pend && (rsp_owner == OWN_INST);
   assign data_rsp_valid  = rsp_pend && (rsp_owner == OWN_DATA);
   assign probe_rsp_valid = rsp_pend && (rsp_owner == OWN_PROBE);

   // Starvation counter counts blocked cycles too
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= 3'd0;
      end else if (!inst_req || gnt_inst || cancel) begin
         starve_cnt <= 3'd0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

endmodule
